// File: rtl/bram_loader_if.sv
// rtl/bram_loader_if.sv - stream input and blk_mem_gen port A bundle for bram_loader
interface bram_loader_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              bram_ena;
   logic              bram_wea;
   logic [ADDR_W-1:0] bram_addra;
   logic [DATA_W-1:0] bram_dina;
   logic [DATA_W-1:0] bram_douta;

   // Loader side: consumes the stream, drives the BRAM port.
   modport slave (
      input  in_data, in_valid, bram_douta,
      output in_ready, bram_ena, bram_wea, bram_addra, bram_dina
   );

   // Environment side: stream source plus the BRAM itself.
   modport master (
      output in_data, in_valid, bram_douta,
      input  in_ready, bram_ena, bram_wea, bram_addra, bram_dina
   );
endinterface

// File: rtl/bram_loader.sv
// rtl/bram_loader.sv - streams words into BRAM port A, optionally reads them back and counts mismatches
module bram_loader #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1,
   parameter int VERIFY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   bram_loader_if.slave      bus,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   mismatch_cnt
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_VERIFY,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W:0]   len_q;
   logic [1:0]        drain_cnt;

   logic [DATA_W-1:0] shadow [DEPTH];
   logic [RD_LAT-1:0] rd_vld;
   logic [ADDR_W-1:0] rd_addr [RD_LAT];

   logic              cmp_fail;

   // A read is in flight when the port shows ena without wea; its data
   // arrives RD_LAT cycles later, so the last pipeline stage lines up with douta.
   assign cmp_fail = rd_vld[RD_LAT-1] && (bus.bram_douta != shadow[rd_addr[RD_LAT-1]]);

   // Shadow copy of every accepted word, the reference for read-back.
   always_ff @(posedge clk) begin
      if (bus.in_ready && bus.in_valid) begin
         shadow[ptr] <= bus.in_data;
      end
   end

   // Carry each issued read address down the latency pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            rd_addr[i] <= '0;
         end
      end else begin
         rd_vld[0]  <= bus.bram_ena & ~bus.bram_wea;
         rd_addr[0] <= bus.bram_addra;
         for (int i = 1; i < RD_LAT; i++) begin
            rd_vld[i]  <= rd_vld[i-1];
            rd_addr[i] <= rd_addr[i-1];
         end
      end
   end

   // Load sequencer with registered BRAM, handshake and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         ptr             <= '0;
         remaining       <= '0;
         base_q          <= '0;
         len_q           <= '0;
         drain_cnt       <= '0;
         bus.in_ready    <= 1'b0;
         bus.bram_ena    <= 1'b0;
         bus.bram_wea    <= 1'b0;
         bus.bram_addra  <= '0;
         bus.bram_dina   <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         mismatch_cnt    <= '0;
      end else begin
         done         <= 1'b0;
         bus.bram_ena <= 1'b0;
         bus.bram_wea <= 1'b0;

         if (cmp_fail && (mismatch_cnt != '1)) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  ptr          <= base_addr;
                  base_q       <= base_addr;
                  remaining    <= length;
                  len_q        <= length;
                  mismatch_cnt <= '0;
                  if (length == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state        <= ST_WRITE;
                     bus.in_ready <= 1'b1;
                     busy         <= 1'b1;
                  end
               end
            end

            ST_WRITE: begin
               if (bus.in_valid) begin
                  bus.bram_ena   <= 1'b1;
                  bus.bram_wea   <= 1'b1;
                  bus.bram_addra <= ptr;
                  bus.bram_dina  <= bus.in_data;
                  ptr            <= ptr + 1'b1;
                  remaining      <= remaining - 1'b1;
                  if (remaining == CNT_ONE) begin
                     bus.in_ready <= 1'b0;
                     if (VERIFY != 0) begin
                        state     <= ST_VERIFY;
                        ptr       <= base_q;
                        remaining <= len_q;
                     end else begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
            end

            ST_VERIFY: begin
               bus.bram_ena   <= 1'b1;
               bus.bram_addra <= ptr;
               ptr            <= ptr + 1'b1;
               remaining      <= remaining - 1'b1;
               if (remaining == CNT_ONE) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= '0;
               end
            end

            // One extra cycle beyond RD_LAT covers the output register on the last read.
            ST_DRAIN: begin
               if (drain_cnt == 2'(RD_LAT)) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/bram_loader.md
Name: bram_loader

Overview:
- Write-side companion to the switch-addressed BRAM read path.
- Accepts a stream of 32-bit words over a valid/ready handshake and writes them to consecutive addresses of the blk_mem_gen port A.
- After writing, optionally reads every written address back and compares it with what was written.
- Reports busy, done, and a mismatch count, so the seven-segment display contents can be loaded at runtime.

Parameters:
- ADDR_W, 3, BRAM address width; depth = 2^ADDR_W.
- DATA_W, 32, word width.
- RD_LAT, 1, BRAM read latency in cycles from address to douta; legal values are 1 or 2.
- VERIFY, 1, 1 enables the read-back compare phase; 0 skips it.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first address to write; captured on start.
- length  in  ADDR_W+1  number of words, 0..2^ADDR_W; captured on start.
- in_data  in  DATA_W  stream data.
- in_valid  in  1  stream data valid.
- in_ready  out  1  loader can accept a word this cycle.
- bram_ena  out  1  to blk_mem_gen ena.
- bram_wea  out  1  to blk_mem_gen wea.
- bram_addra  out  ADDR_W  to blk_mem_gen addra.
- bram_dina  out  DATA_W  to blk_mem_gen dina.
- bram_douta  in  DATA_W  from blk_mem_gen douta.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse when the load and verify complete.
- mismatch_cnt  out  ADDR_W+1  number of failed compares in the last load; holds its value until the next start.

Behaviour:
- Reset values: all outputs are 0, and the FSM is in IDLE. Reset asserted mid-operation aborts the load at once; BRAM contents already written stay in the BRAM.
- States: IDLE, WRITE, VERIFY, DRAIN, DONE.
- IDLE, on start:
  - capture base_addr into the address pointer, length into the remaining count, and clear mismatch_cnt;
  - if length==0, go to DONE; otherwise go to WRITE.
  - A start outside IDLE is ignored.
- WRITE:
  - in_ready=1.
  - On an in_valid&in_ready cycle, register bram_ena=1, bram_wea=1, bram_addra=pointer, bram_dina=in_data (the BRAM sees the write one cycle after the handshake), then increment the pointer modulo 2^ADDR_W and decrement the remaining count.
  - Cycles without in_valid drive bram_ena=0 and bram_wea=0.
  - Throughput is one word per cycle.
  - When the last word is accepted, in_ready drops in the following cycle. The next state is VERIFY if VERIFY=1, otherwise DONE.
- VERIFY:
  - in_ready=0 and bram_wea=0.
  - Reset the pointer to base_addr and issue one read per cycle (bram_ena=1) for length addresses, wrapping as in WRITE.
  - The expected data comes from a shadow copy of each written word, kept in an internal 2^ADDR_W × DATA_W register array indexed by address.
  - Each issued read carries its address down an RD_LAT-deep pipeline. Compare bram_douta with the shadow word RD_LAT cycles after issue.
  - After the last read is issued, go to DRAIN.
- DRAIN:
  - Wait RD_LAT cycles for the outstanding compares to finish, then go to DONE.
  - mismatch_cnt increments by 1 per failed compare and saturates at 2^(ADDR_W+1)-1.
- DONE: assert done=1 for exactly one cycle, then return to IDLE. busy=0 in DONE.
- Wrap-around: base_addr + length > depth wraps to address 0. If length equals depth, every location is written exactly once.
- Simultaneous events: start arriving in the same cycle as DONE is ignored; start is accepted on the following IDLE cycle.
- Outside WRITE, in_ready=0 and no stream word is consumed, even when in_valid=1.

Test Plan:
- Reset, then start with base_addr=0, length=8, and in_valid held high with data 0x11111111·k for k=0..7:
  - bram_wea is high for 8 consecutive cycles at addresses 0..7;
  - VERIFY issues 8 reads;
  - done pulses with mismatch_cnt=0 and busy low afterwards.
- base_addr=6, length=4, with in_valid toggling every other cycle: writes go to addresses 6,7,0,1 with the matching data; in_ready drops after the 4th handshake; done pulses.
- Same as the previous case with the BRAM model corrupting address 7 on read: mismatch_cnt=1 at done.
- length=0: done pulses within 2 cycles of start, and no bram_ena pulse occurs.
- Assert rst_n low after 3 of 8 words:
  - all outputs return to 0 asynchronously;
  - addresses 0..2 keep the written data;
  - a new start then runs normally.
- Start pulses issued during WRITE and during VERIFY: no effect on the pointer or the count. Repeat the first case with RD_LAT=2 and VERIFY=0: RD_LAT=2 gives correct compares; VERIFY=0 pulses done directly after the last write.
